// File: rtl/microwave_timer.sv
// Cook-time sequencer: holds the programmed time and requests start from the cook controller.
// Counts seconds while heat is active, pulses finish on expiry, and duty-cycles the magnetron by power.
module microwave_timer #(
    parameter int CLK_DIV = 50000000,
    parameter int TW      = 12,
    parameter int ADD_SEC = 30,
    parameter int PWR_WIN = 10
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          key_start,
    input  logic          key_clear,
    input  logic          key_add,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic [3:0]    power,
    input  logic          heat,
    output logic          start,
    output logic          finish,
    output logic          mag_on,
    output logic [TW-1:0] time_left,
    output logic          running
);

    localparam int              PW         = $clog2(CLK_DIV);
    localparam logic [PW-1:0]   PRE_LAST   = PW'(CLK_DIV - 1);
    localparam logic [3:0]      PWR_MAX    = 4'(PWR_WIN);
    localparam logic [3:0]      PHASE_LAST = 4'(PWR_WIN - 1);
    localparam logic [TW-1:0]   TIME_MAX   = {TW{1'b1}};
    localparam logic [TW:0]     ADD_INC    = (TW+1)'(ADD_SEC);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        HOLD,
        DONE
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] prescaler, prescaler_n;
    logic [3:0]    phase, phase_n;
    logic [TW-1:0] time_n;
    logic          start_n, finish_n, mag_n, running_n;

    logic          counting, sec_tick;
    logic [TW-1:0] base_time, added_time, run_time;
    logic [TW:0]   add_sum;
    logic [3:0]    pwr_eff;

    // A key_add landing on a second tick adds to the already-decremented time.
    always_comb begin
        counting   = (state == RUN) && heat;
        sec_tick   = counting && (prescaler == PRE_LAST);
        base_time  = (sec_tick && (time_left != '0)) ? time_left - TW'(1) : time_left;
        add_sum    = {1'b0, base_time} + ADD_INC;
        added_time = add_sum[TW] ? TIME_MAX : add_sum[TW-1:0];
        run_time   = key_add ? added_time : base_time;
        pwr_eff    = (power > PWR_MAX) ? PWR_MAX : power;
    end

    always_comb begin
        state_n     = state;
        time_n      = time_left;
        prescaler_n = prescaler;
        phase_n     = phase;
        finish_n    = 1'b0;

        if (counting) begin
            prescaler_n = sec_tick ? '0 : prescaler + PW'(1);
            if (sec_tick) begin
                phase_n = (phase >= PHASE_LAST) ? 4'd0 : phase + 4'd1;
            end
        end

        case (state)
            IDLE: begin
                if (key_clear) begin
                    time_n = '0;
                end else if (key_add) begin
                    time_n = added_time;
                end else if (load) begin
                    time_n = load_val;
                end else if (key_start && (time_left != '0)) begin
                    state_n     = ARM;
                    prescaler_n = '0;
                    phase_n     = 4'd0;
                end
            end
            ARM: begin
                if (key_clear) begin
                    state_n = IDLE;
                    time_n  = '0;
                end else begin
                    if (key_add) begin
                        time_n = added_time;
                    end
                    if (heat) begin
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                if (key_clear) begin
                    state_n  = DONE;
                    time_n   = '0;
                    finish_n = 1'b1;
                end else begin
                    time_n = run_time;
                    if (sec_tick && (run_time == '0)) begin
                        state_n  = DONE;
                        finish_n = 1'b1;
                    end else if (!heat) begin
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                // A cleared hold has time_left==0; it finishes once heat returns.
                if (key_clear) begin
                    time_n = '0;
                end else begin
                    if (key_add) begin
                        time_n = added_time;
                    end
                    if (heat) begin
                        if (!key_add && (time_left == '0)) begin
                            state_n  = DONE;
                            finish_n = 1'b1;
                        end else begin
                            state_n = RUN;
                        end
                    end
                end
            end
            DONE: begin
                if (key_clear) begin
                    state_n = IDLE;
                    time_n  = '0;
                end else if (key_add) begin
                    state_n = IDLE;
                    time_n  = added_time;
                end else if (load) begin
                    state_n = IDLE;
                    time_n  = load_val;
                end
            end
            default: begin
                state_n = IDLE;
                time_n  = '0;
            end
        endcase

        start_n   = (state_n == ARM);
        running_n = (state_n == ARM) || (state_n == RUN) || (state_n == HOLD);
        mag_n     = (state_n == RUN) && heat && (phase_n < pwr_eff);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            time_left <= '0;
            prescaler <= '0;
            phase     <= 4'd0;
            start     <= 1'b0;
            finish    <= 1'b0;
            mag_on    <= 1'b0;
            running   <= 1'b0;
        end else begin
            state     <= state_n;
            time_left <= time_n;
            prescaler <= prescaler_n;
            phase     <= phase_n;
            start     <= start_n;
            finish    <= finish_n;
            mag_on    <= mag_n;
            running   <= running_n;
        end
    end

endmodule

// File: doc/microwave_timer.md
Name: microwave_timer

Overview:
- Cook-time sequencer that sits beside the microwave door/cook controller.
- Holds the programmed cook time and raises that controller's `start` input.
- Counts seconds only while the controller reports `heat` active, and pulses `finish` when the time expires.
- Duty-cycles the magnetron enable by power level. It is the only source of `start`/`finish` for the cook controller.

Parameters:
- CLK_DIV, 50000000, clk cycles per second; must be ≥ 2.
- TW, 12, width of the seconds counter; max time is 2^TW-1 s.
- ADD_SEC, 30, seconds added per `key_add` press.
- PWR_WIN, 10, power window length in seconds.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- key_start  in  1  start key, 1-cycle pulse.
- key_clear  in  1  clear/abort key, 1-cycle pulse.
- key_add  in  1  add-ADD_SEC key, 1-cycle pulse.
- load  in  1  load `load_val` into the time counter.
- load_val  in  TW  seconds to load.
- power  in  4  power level 0..PWR_WIN; values above PWR_WIN are treated as PWR_WIN.
- heat  in  1  heat output of the cook controller.
- start  out  1  start request to the cook controller (level).
- finish  out  1  finish to the cook controller, 1-cycle pulse.
- mag_on  out  1  duty-cycled magnetron enable.
- time_left  out  TW  remaining seconds.
- running  out  1  high in ARM, RUN and HOLD.

Behaviour:
- Reset:
  - Clock is clk; reset is nrst, asynchronous, active low.
  - On reset: state IDLE; time_left=0, prescaler=0, phase=0; start=finish=mag_on=running=0.
  - Reset takes effect immediately, including mid-run.
- States: IDLE, ARM, RUN, HOLD, DONE. All outputs are registered.
- IDLE:
  - key_start with time_left>0 → ARM. key_start with time_left=0 is ignored.
  - prescaler and phase are cleared on entry to ARM.
- ARM:
  - start=1, held until heat=1 is seen; this covers the door being open at the time of the press.
  - heat=1 → RUN, start=0 from that cycle.
- RUN:
  - prescaler increments each cycle. At CLK_DIV-1 it wraps to 0 and generates sec_tick.
  - sec_tick: time_left decrements by 1; phase increments and wraps at PWR_WIN-1→0.
  - heat=0 → HOLD.
- HOLD:
  - prescaler, phase and time_left are frozen.
  - heat=1 → RUN, counting resumes from the frozen prescaler value.
- Expiry:
  - sec_tick that takes time_left to 0 → DONE.
  - finish=1 for exactly the next cycle; mag_on=0 in DONE.
- DONE:
  - key_start is ignored.
  - load or key_add → IDLE with the new time.
- mag_on: = heat & (state==RUN) & (phase < power). Consequences:
  - power=0: never on, but the timer still runs.
  - power≥PWR_WIN: always on.
- Key handling and priority (per cycle): key_clear > key_add > load > key_start.
- key_clear:
  - IDLE/DONE/ARM → IDLE, time_left=0, start=0.
  - RUN → time_left=0, finish pulse next cycle, → DONE.
  - HOLD → time_left=0, stay in HOLD. On heat=1, go directly to DONE with a finish pulse; no RUN cycle counts.
- key_add:
  - Any state: time_left = min(time_left+ADD_SEC, 2^TW-1).
  - From DONE → IDLE.
  - Same cycle as a sec_tick: time_left = sat(time_left-1+ADD_SEC). Expiry occurs only if the result is 0.
- load:
  - Accepted in IDLE/DONE only (→ IDLE, time_left=load_val).
  - Ignored in ARM/RUN/HOLD.
- No other state changes time_left.

Test Plan:
1. CLK_DIV=4, TW=8, with a bench model of the cook controller. Load 3, key_start →
   - start=1 until heat rises;
   - time_left 3→2→1→0 at 4-cycle intervals of heat;
   - finish high exactly 1 cycle, then DONE, running=0.
2. Time 3. Open the door after 5 RUN cycles →
   - HOLD with time_left=2 and prescaler=1 frozen;
   - after close, finish arrives after exactly 7 more heat cycles.
3. power=3, time 20 →
   - mag_on high during seconds 0-2 and 10-12 only (24 cycles total);
   - power=0 gives mag_on=0 throughout; power=15 gives mag_on=1 throughout RUN.
4. TW=8:
   - time_left=250 + key_add → 255;
   - key_add on the final sec_tick (time_left=1) → 30, no finish.
5. key_clear in RUN → finish next cycle, time_left=0. key_clear in HOLD → no finish until heat returns, then a 1-cycle finish.
6. nrst low mid-RUN → all outputs 0 immediately. key_start with time_left=0 → start stays 0.
